// File: rtl/regs_int_ctrl.sv
// regs_int_ctrl
//
// Command-driven master for a register-file block. Accepts one single-beat
// command at a time from a host link, keeps shadow copies of the register
// initial values (regi) and the read-only mask (mode_mask), issues load_regs
// commit strobes followed by a settle window, and returns exactly one
// response per accepted command.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (ready only while idle)
//   cmd_op                   00 WRITE, 01 READ, 10 COMMIT, 11 MASK
//   cmd_addr, cmd_data       register index and write data (MASK uses bit 0)
//   rsp_valid / rsp_ready    response handshake
//   rsp_data, rsp_err        read data (0 for non-READ) and reject flag
//   regi                     shadow initial values, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   load_regs                one-cycle commit strobe
//   mode_mask                1 = register is read-only
//   rego                     current register values, same packing as regi
//
// state  | meaning
// IDLE   | ready for a command
// EXEC   | apply WRITE/READ/MASK side effect, build response
// LOAD   | load_regs strobe, arm settle counter
// SETTLE | wait for the register block to settle after a commit
// RESP   | hold response until the host takes it

module regs_int_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int DATA_DEPTH    = 16,
  parameter int ADDR_WIDTH    = $clog2(DATA_DEPTH),
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [1:0]                       cmd_op,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_data,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             rsp_err,
  output logic [DATA_DEPTH*DATA_WIDTH-1:0] regi,
  output logic                             load_regs,
  output logic [DATA_DEPTH-1:0]            mode_mask,
  input  logic [DATA_DEPTH*DATA_WIDTH-1:0] rego
);

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [1:0] OP_COMMIT = 2'b10;
  localparam logic [1:0] OP_MASK   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_LOAD,
    S_SETTLE,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [3:0]            settle_cnt;

  logic                  addr_err;
  logic                  sel_mask;
  logic [DATA_WIDTH-1:0] sel_rego;
  logic                  exec_err;
  logic [DATA_WIDTH-1:0] exec_rdata;
  logic                  do_write;
  logic                  do_mask;

  // Address decode by comparison so out-of-range indices (non power-of-two
  // depth) never select anything instead of indexing past the vectors.
  always_comb begin
    addr_err = (32'(addr_q) >= DATA_DEPTH);
    sel_mask = 1'b0;
    sel_rego = '0;
    for (int i = 0; i < DATA_DEPTH; i++) begin
      if (addr_q == ADDR_WIDTH'(i)) begin
        sel_mask = mode_mask[i];
        sel_rego = rego[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    exec_err   = addr_err;
    exec_rdata = '0;
    do_write   = 1'b0;
    do_mask    = 1'b0;
    case (op_q)
      OP_WRITE: begin
        if (!addr_err && sel_mask) exec_err = 1'b1;
        do_write = !addr_err && !sel_mask;
      end
      OP_READ: begin
        if (!addr_err) exec_rdata = sel_rego;
      end
      OP_MASK: begin
        do_mask = !addr_err;
      end
      default: begin
        exec_err = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) state_d = (cmd_op == OP_COMMIT) ? S_LOAD : S_EXEC;
      end
      S_EXEC:   state_d = S_RESP;
      S_LOAD:   state_d = (SETTLE_CYCLES == 0) ? S_RESP : S_SETTLE;
      S_SETTLE: begin
        if (settle_cnt <= 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Strobes are registered from the next state so they line up with the
  // state they belong to without a combinational path to the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      settle_cnt <= '0;
      regi       <= '0;
      mode_mask  <= '0;
      load_regs  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      load_regs <= (state_d == S_LOAD);
      rsp_valid <= (state_d == S_RESP);

      if (state_q == S_IDLE && cmd_valid) begin
        op_q   <= cmd_op;
        addr_q <= cmd_addr;
        data_q <= cmd_data;
      end

      if (state_q == S_EXEC) begin
        rsp_data <= exec_rdata;
        rsp_err  <= exec_err;
        for (int i = 0; i < DATA_DEPTH; i++) begin
          if (addr_q == ADDR_WIDTH'(i)) begin
            if (do_write) regi[i*DATA_WIDTH +: DATA_WIDTH] <= data_q;
            if (do_mask)  mode_mask[i] <= data_q[0];
          end
        end
      end

      if (state_q == S_LOAD) begin
        settle_cnt <= 4'(SETTLE_CYCLES);
        rsp_data   <= '0;
        rsp_err    <= 1'b0;
      end

      if (state_q == S_SETTLE) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_regs_int_ctrl.sv
module tb_regs_int_ctrl;
  localparam int W  = 8;
  localparam int D  = 12;
  localparam int AW = 4;
  localparam int S  = 2;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [1:0] OP_COMMIT = 2'b10;
  localparam logic [1:0] OP_MASK   = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [W-1:0]  cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_data;
  logic          rsp_err;
  logic [D*W-1:0] regi;
  logic          load_regs;
  logic [D-1:0]  mode_mask;
  logic [D*W-1:0] rego = '0;

  regs_int_ctrl #(
    .DATA_WIDTH(W), .DATA_DEPTH(D), .ADDR_WIDTH(AW), .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .regi(regi), .load_regs(load_regs),
    .mode_mask(mode_mask), .rego(rego)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: plain arrays of register contents.
  logic [W-1:0] m_regi [D];
  logic [W-1:0] m_rego [D];
  bit           m_mask [D];

  bit           exp_ready, exp_rv, exp_load, exp_rerr;
  logic [W-1:0] exp_rdata;
  bit           chk_en = 1'b0;
  logic [W-1:0] last_rdata;
  logic         last_rerr;

  function automatic logic [D*W-1:0] pack_regi();
    logic [D*W-1:0] v;
    for (int i = 0; i < D; i++) v[i*W +: W] = m_regi[i];
    return v;
  endfunction

  function automatic logic [D*W-1:0] pack_rego();
    logic [D*W-1:0] v;
    for (int i = 0; i < D; i++) v[i*W +: W] = m_rego[i];
    return v;
  endfunction

  function automatic logic [D-1:0] pack_mask();
    logic [D-1:0] v;
    for (int i = 0; i < D; i++) v[i] = m_mask[i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_regi[i] = '0;
      m_mask[i] = 1'b0;
    end
    exp_ready = 1'b1;
    exp_rv    = 1'b0;
    exp_load  = 1'b0;
    exp_rerr  = 1'b0;
    exp_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("rst_load_regs", 128'(load_regs), 128'(0));
      chk("rst_rsp_data",  128'(rsp_data),  128'(0));
      chk("rst_rsp_err",   128'(rsp_err),   128'(0));
      chk("rst_regi",      128'(regi),      128'(0));
      chk("rst_mode_mask", 128'(mode_mask), 128'(0));
    end else if (chk_en) begin
      chk("cmd_ready", 128'(cmd_ready), 128'(exp_ready));
      chk("rsp_valid", 128'(rsp_valid), 128'(exp_rv));
      chk("load_regs", 128'(load_regs), 128'(exp_load));
      chk("regi",      128'(regi),      128'(pack_regi()));
      chk("mode_mask", 128'(mode_mask), 128'(pack_mask()));
      if (exp_rv) begin
        chk("rsp_data", 128'(rsp_data), 128'(exp_rdata));
        chk("rsp_err",  128'(rsp_err),  128'(exp_rerr));
        last_rdata = rsp_data;
        last_rerr  = rsp_err;
      end
    end
  end

  // Presents one command in the current (idle) cycle and walks the expected
  // cycle-by-cycle behaviour until the response is taken.
  task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                        input logic [W-1:0] data, input int stall, input bit junk);
    bit           err;
    bit           rerr;
    bit           w_en;
    bit           m_en;
    logic [W-1:0] rdata;
    int           a;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    tick();
    cmd_valid = junk;
    cmd_op    = 2'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_data  = W'($urandom);
    rsp_ready = 1'($urandom);
    exp_ready = 1'b0;
    exp_load  = (op == OP_COMMIT);
    a     = int'(addr);
    err   = (a >= D);
    rerr  = err;
    rdata = '0;
    w_en  = 1'b0;
    m_en  = 1'b0;
    case (op)
      OP_WRITE: if (!err) begin
        if (m_mask[a]) rerr = 1'b1;
        else           w_en = 1'b1;
      end
      OP_READ:  if (!err) rdata = m_rego[a];
      OP_MASK:  m_en = !err;
      default:  rerr = 1'b0;
    endcase
    tick();
    exp_load = 1'b0;
    if (op == OP_COMMIT) begin
      for (int i = 0; i < D; i++) m_rego[i] = m_regi[i];
      rego = pack_rego();
      repeat (S) tick();
    end else begin
      if (w_en) m_regi[a] = data;
      if (m_en) m_mask[a] = data[0];
    end
    exp_rv    = 1'b1;
    exp_rdata = rdata;
    exp_rerr  = rerr;
    rsp_ready = 1'b0;
    repeat (stall) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    exp_rv    = 1'b0;
    exp_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < D; i++) m_rego[i] = W'($urandom);
    rego = pack_rego();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    do_cmd(OP_WRITE, 4'd3, 8'hA5, 0, 1'b0);
    chk("wr3_regi", 128'(regi[3*W +: W]), 128'(8'hA5));
    chk("wr3_err",  128'(last_rerr),  128'(0));
    chk("wr3_data", 128'(last_rdata), 128'(0));

    do_cmd(OP_COMMIT, 4'd0, 8'h00, 0, 1'b0);
    do_cmd(OP_READ, 4'd3, 8'h00, 1, 1'b0);
    chk("rd3_after_commit", 128'(last_rdata), 128'(8'hA5));

    do_cmd(OP_MASK, 4'd5, 8'h01, 0, 1'b0);
    do_cmd(OP_WRITE, 4'd5, 8'h3C, 0, 1'b1);
    chk("wr5_ro_err",  128'(last_rerr), 128'(1));
    chk("wr5_ro_regi", 128'(regi[5*W +: W]), 128'(8'h00));
    do_cmd(OP_MASK, 4'd5, 8'h00, 0, 1'b0);
    do_cmd(OP_WRITE, 4'd5, 8'h3C, 0, 1'b0);
    chk("wr5_rw_err",  128'(last_rerr), 128'(0));
    chk("wr5_rw_regi", 128'(regi[5*W +: W]), 128'(8'h3C));

    do_cmd(OP_READ, 4'd13, 8'h00, 0, 1'b0);
    chk("rd13_err",  128'(last_rerr),  128'(1));
    chk("rd13_data", 128'(last_rdata), 128'(0));
    do_cmd(OP_MASK, 4'd14, 8'h01, 0, 1'b0);
    chk("mask14_err",  128'(last_rerr), 128'(1));
    chk("mask14_mask", 128'(mode_mask), 128'(0));

    do_cmd(OP_READ, 4'd3, 8'h00, 10, 1'b1);
    chk("bp_rd3_data", 128'(last_rdata), 128'(8'hA5));
    do_cmd(OP_WRITE, 4'd7, 8'h11, 0, 1'b0);
    chk("bp_next_regi", 128'(regi[7*W +: W]), 128'(8'h11));

    for (int n = 0; n < 200; n++) begin
      do_cmd(2'($urandom), AW'($urandom_range(0, 15)), W'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom));
      if ($urandom_range(0, 3) == 0) tick();
    end

    // Reset during the settle window of a commit.
    cmd_valid = 1'b1;
    cmd_op    = OP_COMMIT;
    tick();
    cmd_valid = 1'b0;
    exp_ready = 1'b0;
    exp_load  = 1'b1;
    tick();
    exp_load = 1'b0;
    for (int i = 0; i < D; i++) m_rego[i] = m_regi[i];
    rego = pack_rego();
    #1;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) tick();
    do_cmd(OP_WRITE, 4'd3, 8'h5A, 0, 1'b0);
    chk("post_rst_regi", 128'(regi[3*W +: W]), 128'(8'h5A));
    chk("post_rst_err",  128'(last_rerr), 128'(0));
    do_cmd(OP_READ, 4'd3, 8'h00, 0, 1'b0);

    chk_en = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
